// File: rtl/pong_game_ctrl.sv
// Pong game controller: sequences serve / play / pause / miss / game-over,
// tracks score, lives and puck speed, and drives the pong_ball control lines.
// Frame timing is derived from the falling edge of vsync.
module pong_game_ctrl #(
    parameter int INIT_SPEED     = 4,
    parameter int MAX_SPEED      = 12,
    parameter int HITS_PER_LEVEL = 4,
    parameter int SERVE_FRAMES   = 60,
    parameter int MISS_FRAMES    = 90,
    parameter int LIVES          = 3
) (
    input  logic       vclock,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic       pause,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_enabled,
    output logic       ball_reset,
    output logic [3:0] pspeed,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_MISS  = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    localparam int MAX_FRAMES = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam int HIT_W      = $clog2(HITS_PER_LEVEL + 1);

    logic             vsync_q;
    logic             tick;
    logic             frame_expired;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [HIT_W-1:0] hit_inc;
    logic [7:0]       score_q, score_d;
    logic [3:0]       pspeed_q, pspeed_d;
    logic [1:0]       lives_q, lives_d;
    logic             ball_en_q, ball_en_d;
    logic             ball_rst_q, ball_rst_d;

    // One-cycle frame tick on each falling edge of vsync.
    assign tick          = vsync_q & ~vsync;
    // The timed states leave on the tick that would take the counter from 1 to 0.
    assign frame_expired = tick && (frame_cnt_q == CNT_W'(1));
    assign hit_inc       = hit_cnt_q + HIT_W'(1);

    // vsync edge-detect register.
    always_ff @(posedge vclock) begin
        if (reset) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    // FSM state register.
    always_ff @(posedge vclock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a miss outranks pause (and hit) in PLAY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) state_d = S_SERVE;
            end
            S_SERVE: begin
                if (frame_expired) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (miss) begin
                    state_d = (lives_q == 2'd1) ? S_OVER : S_MISS;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause) state_d = S_PLAY;
            end
            S_MISS: begin
                if (frame_expired) state_d = S_SERVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output logic, computed from the next state so the flops track the state.
    always_comb begin
        ball_en_d  = (state_d == S_PLAY);
        ball_rst_d = (state_d == S_IDLE) || (state_d == S_SERVE) || (state_d == S_MISS);
    end

    // Game datapath: score, lives, speed, hit count and frame counter updates.
    always_comb begin
        score_d     = score_q;
        lives_d     = lives_q;
        pspeed_d    = pspeed_q;
        hit_cnt_d   = hit_cnt_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    score_d   = 8'd0;
                    lives_d   = 2'(LIVES);
                    pspeed_d  = 4'(INIT_SPEED);
                    hit_cnt_d = '0;
                end
            end
            S_SERVE, S_MISS: begin
                if (tick) frame_cnt_d = frame_cnt_q - CNT_W'(1);
            end
            S_PLAY: begin
                if (miss) begin
                    // A simultaneous hit is discarded.
                    lives_d   = lives_q - 2'd1;
                    pspeed_d  = 4'(INIT_SPEED);
                    hit_cnt_d = '0;
                end else if (hit) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if (hit_inc == HIT_W'(HITS_PER_LEVEL)) begin
                        hit_cnt_d = '0;
                        if (pspeed_q < 4'(MAX_SPEED)) pspeed_d = pspeed_q + 4'd1;
                    end else begin
                        hit_cnt_d = hit_inc;
                    end
                end
            end
            default: ;
        endcase

        // Load the frame counter on entry into a timed state.
        if ((state_d == S_SERVE) && (state_q != S_SERVE)) begin
            frame_cnt_d = CNT_W'(SERVE_FRAMES);
        end else if ((state_d == S_MISS) && (state_q != S_MISS)) begin
            frame_cnt_d = CNT_W'(MISS_FRAMES);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge vclock) begin
        if (reset) begin
            score_q     <= 8'd0;
            lives_q     <= 2'(LIVES);
            pspeed_q    <= 4'(INIT_SPEED);
            hit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            ball_en_q   <= 1'b0;
            ball_rst_q  <= 1'b1;
        end else begin
            score_q     <= score_d;
            lives_q     <= lives_d;
            pspeed_q    <= pspeed_d;
            hit_cnt_q   <= hit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ball_en_q   <= ball_en_d;
            ball_rst_q  <= ball_rst_d;
        end
    end

    assign ball_enabled = ball_en_q;
    assign ball_reset   = ball_rst_q;
    assign pspeed       = pspeed_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed stimulus, a behavioural game model
// checked every cycle, and literal expectations at key points.
module tb_pong_game_ctrl;

    localparam int INIT_SPEED     = 4;
    localparam int MAX_SPEED      = 12;
    localparam int HITS_PER_LEVEL = 4;
    localparam int SERVE_FRAMES   = 60;
    localparam int MISS_FRAMES    = 90;
    localparam int LIVES          = 3;

    localparam int ST_IDLE  = 0;
    localparam int ST_SERVE = 1;
    localparam int ST_PLAY  = 2;
    localparam int ST_PAUSE = 3;
    localparam int ST_MISS  = 4;
    localparam int ST_OVER  = 5;

    logic       vclock = 1'b0;
    logic       reset  = 1'b1;
    logic       vsync  = 1'b0;
    logic       start  = 1'b0;
    logic       pause  = 1'b0;
    logic       hit    = 1'b0;
    logic       miss   = 1'b0;
    logic       ball_enabled;
    logic       ball_reset;
    logic [3:0] pspeed;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pong_game_ctrl #(
        .INIT_SPEED    (INIT_SPEED),
        .MAX_SPEED     (MAX_SPEED),
        .HITS_PER_LEVEL(HITS_PER_LEVEL),
        .SERVE_FRAMES  (SERVE_FRAMES),
        .MISS_FRAMES   (MISS_FRAMES),
        .LIVES         (LIVES)
    ) dut (
        .vclock      (vclock),
        .reset       (reset),
        .vsync       (vsync),
        .start       (start),
        .pause       (pause),
        .hit         (hit),
        .miss        (miss),
        .ball_enabled(ball_enabled),
        .ball_reset  (ball_reset),
        .pspeed      (pspeed),
        .score       (score),
        .lives       (lives),
        .state       (state)
    );

    always #5 vclock = ~vclock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural game model: counts ticks up from state entry.
    int m_state, m_score, m_lives, m_speed, m_hits, m_ticks;
    bit m_vs_prev, m_tk;

    always @(posedge vclock) begin
        m_tk = m_vs_prev && !vsync;
        if (reset) begin
            m_state = ST_IDLE; m_score = 0; m_lives = LIVES; m_speed = INIT_SPEED;
            m_hits = 0; m_ticks = 0; m_vs_prev = 1'b0;
        end else begin
            m_vs_prev = vsync;
            case (m_state)
                ST_IDLE, ST_OVER: if (start) begin
                    m_state = ST_SERVE; m_score = 0; m_lives = LIVES;
                    m_speed = INIT_SPEED; m_hits = 0; m_ticks = 0;
                end
                ST_SERVE: if (m_tk) begin
                    m_ticks++;
                    if (m_ticks == SERVE_FRAMES) begin m_state = ST_PLAY; m_ticks = 0; end
                end
                ST_MISS: if (m_tk) begin
                    m_ticks++;
                    if (m_ticks == MISS_FRAMES) begin m_state = ST_SERVE; m_ticks = 0; end
                end
                ST_PLAY: begin
                    if (miss) begin
                        m_lives--; m_speed = INIT_SPEED; m_hits = 0; m_ticks = 0;
                        m_state = (m_lives == 0) ? ST_OVER : ST_MISS;
                    end else begin
                        if (hit) begin
                            if (m_score < 255) m_score++;
                            m_hits++;
                            if (m_hits == HITS_PER_LEVEL) begin
                                m_hits = 0;
                                if (m_speed < MAX_SPEED) m_speed++;
                            end
                        end
                        if (pause) m_state = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (pause) m_state = ST_PLAY;
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of DUT against the model.
    always @(negedge vclock) begin
        if (chk_en) begin
            check("state", int'(state), m_state);
            check("score", int'(score), m_score);
            check("lives", int'(lives), m_lives);
            check("pspeed", int'(pspeed), m_speed);
            check("ball_enabled", int'(ball_enabled), int'(m_state == ST_PLAY));
            check("ball_reset", int'(ball_reset),
                  int'(m_state == ST_IDLE || m_state == ST_SERVE || m_state == ST_MISS));
        end
    end

    task automatic cyc(input bit r, input bit s, input bit p, input bit h, input bit m, input bit v);
        @(negedge vclock);
        reset = r; start = s; pause = p; hit = h; miss = m; vsync = v;
        @(posedge vclock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        $display("reset: state=%0d ball_reset=%0b lives=%0d pspeed=%0d", state, ball_reset, lives, pspeed);
        check("lit_reset_state", int'(state), 0);
        check("lit_reset_ball_reset", int'(ball_reset), 1);
        check("lit_reset_lives", int'(lives), 3);
        check("lit_reset_pspeed", int'(pspeed), 4);

        // Game inputs ignored in IDLE.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("lit_idle_ignore", int'(state), 0);

        cyc(0, 1, 0, 0, 0, 0);
        $display("start: state=%0d", state);
        check("lit_start_serve", int'(state), 1);

        ticks(59);
        check("lit_serve_59", int'(state), 1);
        ticks(1);
        $display("serve done: state=%0d ball_enabled=%0b pspeed=%0d", state, ball_enabled, pspeed);
        check("lit_play_state", int'(state), 2);
        check("lit_play_enabled", int'(ball_enabled), 1);
        check("lit_play_pspeed", int'(pspeed), 4);

        cyc(0, 1, 0, 0, 0, 0);
        check("lit_start_in_play", int'(state), 2);

        hits(8);
        $display("8 hits: score=%0d pspeed=%0d", score, pspeed);
        check("lit_score8", int'(score), 8);
        check("lit_pspeed6", int'(pspeed), 6);
        hits(40);
        $display("48 hits: score=%0d pspeed=%0d", score, pspeed);
        check("lit_score48", int'(score), 48);
        check("lit_pspeed_sat", int'(pspeed), 12);

        cyc(0, 0, 1, 0, 0, 0);
        check("lit_pause_state", int'(state), 3);
        check("lit_pause_enabled", int'(ball_enabled), 0);
        cyc(0, 0, 0, 1, 0, 0);
        ticks(3);
        check("lit_pause_frozen", int'(score), 48);
        cyc(0, 0, 1, 0, 0, 0);
        $display("unpause: state=%0d score=%0d", state, score);
        check("lit_unpause_state", int'(state), 2);
        check("lit_unpause_score", int'(score), 48);

        cyc(0, 0, 0, 0, 1, 0);
        $display("miss: state=%0d lives=%0d pspeed=%0d", state, lives, pspeed);
        check("lit_miss_state", int'(state), 4);
        check("lit_miss_lives", int'(lives), 2);
        check("lit_miss_pspeed", int'(pspeed), 4);
        ticks(89);
        check("lit_miss_89", int'(state), 4);
        ticks(1);
        check("lit_miss_to_serve", int'(state), 1);
        ticks(60);
        check("lit_serve_to_play", int'(state), 2);

        // Miss and pause together: miss wins.
        cyc(0, 0, 1, 0, 1, 0);
        $display("miss+pause: state=%0d lives=%0d", state, lives);
        check("lit_misspause_state", int'(state), 4);
        check("lit_misspause_lives", int'(lives), 1);
        ticks(90);
        ticks(60);
        check("lit_back_to_play", int'(state), 2);

        hits(2);
        check("lit_score50", int'(score), 50);
        // Hit and miss together on the last life.
        cyc(0, 0, 0, 1, 1, 0);
        $display("hit+miss last life: state=%0d lives=%0d score=%0d", state, lives, score);
        check("lit_over_state", int'(state), 5);
        check("lit_over_lives", int'(lives), 0);
        check("lit_over_score", int'(score), 50);
        check("lit_over_ball_reset", int'(ball_reset), 0);
        ticks(2);
        cyc(0, 0, 0, 1, 0, 0);
        check("lit_over_hold", int'(score), 50);

        cyc(0, 1, 0, 0, 0, 0);
        $display("restart: state=%0d score=%0d lives=%0d", state, score, lives);
        check("lit_restart_state", int'(state), 1);
        check("lit_restart_score", int'(score), 0);
        check("lit_restart_lives", int'(lives), 3);

        ticks(60);
        hits(17);
        check("lit_score17", int'(score), 17);
        check("lit_pspeed8", int'(pspeed), 8);
        cyc(0, 0, 1, 0, 0, 0);
        check("lit_pause2", int'(state), 3);
        // Reset outranks a simultaneous start.
        cyc(1, 1, 0, 0, 0, 0);
        $display("reset in pause: state=%0d score=%0d ball_reset=%0b", state, score, ball_reset);
        check("lit_rst_state", int'(state), 0);
        check("lit_rst_score", int'(score), 0);
        check("lit_rst_ball_reset", int'(ball_reset), 1);

        cyc(0, 1, 0, 0, 0, 0);
        ticks(60);
        hits(260);
        $display("260 hits: score=%0d pspeed=%0d", score, pspeed);
        check("lit_score_sat", int'(score), 255);
        check("lit_pspeed_sat2", int'(pspeed), 12);

        cyc(0, 0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
